// File: rtl/fetch_unit_pkg.sv
// Shared constants and queue-entry layout for the instruction fetch front end.
// Holds no logic, so it has no latency and no backpressure of its own.
package fetch_unit_pkg;
    localparam int          PC_W_DEF = 10;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [31:0]         insn;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the memory-side and core-side handshakes of the fetch unit.
// master is the fetch unit; slave is the memory/core environment that drives it.
interface fetch_unit_if #(
    parameter int PC_W = 10
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            insn_valid;
    logic            insn_ready;
    logic [31:0]     insn;
    logic [PC_W-1:0] pc;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, insn_valid, insn, pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, insn_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, insn_valid, insn, pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, insn_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// In-order prefetch queue with flush; a push is visible at the head the cycle after it is written.
// No internal backpressure: the caller's credit accounting must keep pushes away from a full queue.
module fetch_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_pop;

    assign do_pop     = pop_i & (count_q != '0);
    assign head_dat_o = mem_q[rd_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    // Pointers wrap naturally, so DEPTH is expected to be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
    end

    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && count_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-limited prefetch, redirect squash and stale-response drop.
// Response to insn_valid is one cycle; requests stall while memory holds ready low or credit is exhausted.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 2;
    localparam int EW = PC_W + 32;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] exp_pc_q, exp_pc_d;
    logic [PC_W-1:0] redirect_pc_al;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            credit, req_acc, rsp_push, rsp_drop, pop;
    logic [EW-1:0]   head_dat;

    assign redirect_pc_al = bus.redirect_pc & ~PC_W'(3);
    // Words already in flight or due to be dropped still own a queue slot.
    assign credit   = (OW'(q_count) + OW'(outst_q) + OW'(drop_q)) < OW'(DEPTH);

    assign bus.imem_req_valid = reset & credit & ~bus.redirect;
    assign bus.imem_addr      = fetch_pc_q;
    assign req_acc  = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_drop = bus.imem_rsp_valid & (drop_q != '0);
    assign rsp_push = bus.imem_rsp_valid & (drop_q == '0) & ~bus.redirect;
    assign pop      = bus.insn_valid & bus.insn_ready & ~bus.redirect;

    assign bus.insn_valid = ~q_empty;
    assign bus.insn       = q_empty ? '0 : head_dat[31:0];
    assign bus.pc         = q_empty ? '0 : head_dat[EW-1:32];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        exp_pc_d   = exp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (bus.redirect) begin
            // Every outstanding word becomes stale; one arriving now is consumed here.
            fetch_pc_d = redirect_pc_al;
            exp_pc_d   = redirect_pc_al;
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_acc)  fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            if (rsp_push) exp_pc_d   = exp_pc_q + PC_W'(PC_STEP);
            outst_d = outst_q + CW'(req_acc) - CW'(rsp_push);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            exp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            exp_pc_q   <= exp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (rsp_push),
        .push_dat_i ({exp_pc_q, bus.imem_rsp_data}),
        .pop_i      (pop),
        .flush_i    (bus.redirect),
        .head_dat_o (head_dat),
        .count_o    (q_count),
        .empty_o    (q_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected pcs/addresses,
// monitors on the falling edge pop and compare against what the DUT presents.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic reset;

    fetch_unit_if #(.PC_W(10)) bus ();

    fetch_unit #(
        .PC_W     (10),
        .DEPTH    (4),
        .RESET_PC (10'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] addr;
        int         due;
    } mreq_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         lat     = 1;
    int         cyc     = 0;
    int         acc_cnt = 0;
    int         acc_base = 0;
    int         pops_seen = 0;
    int         pops_base = 0;
    logic [9:0] exp_q [$];
    logic [9:0] req_q [$];
    mreq_t      mq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return NOP_INSN | {10'd0, a, 12'd0};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 300 && (pops_seen - pops_base) < n; i++) step();
        check("pops_done", 32'((pops_seen - pops_base) >= n), 32'd1);
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.insn_ready     = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        repeat (5) step();
        exp_q.delete();
        req_q.delete();
        pops_base = pops_seen;
        acc_base  = acc_cnt;
    endtask

    // Memory model: fixed latency, responses in request order.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
            acc_cnt++;
            if (req_q.size() > 0) check("req_addr", 32'(bus.imem_addr), 32'(req_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (reset && bus.insn_valid && bus.insn_ready && !bus.redirect) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL insn_unexpected: got pc %h, want no instruction", bus.pc);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("insn_pc", 32'(bus.pc), 32'(e));
                check("insn_data", bus.insn, mem_word(e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        do_reset();

        // Reset state
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'h000);
        check("rst_insn_valid", 32'(bus.insn_valid), 32'd0);
        check("rst_insn", bus.insn, 32'd0);
        check("rst_pc", 32'(bus.pc), 32'd0);

        // 1: streaming with 1-cycle memory
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(10'(i * 4));
            req_q.push_back(10'(i * 4));
        end
        reset = 1'b1; bus.imem_req_ready = 1'b1; bus.insn_ready = 1'b1;
        wait_pops(6);

        // 2: core stalls, credit caps at four
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(10'(i * 4));
        for (int i = 0; i < 5; i++) req_q.push_back(10'(i * 4));
        reset = 1'b1; bus.imem_req_ready = 1'b1;
        repeat (8) step();
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_accepted", 32'(acc_cnt - acc_base), 32'd4);
        check("stall_insn_valid", 32'(bus.insn_valid), 32'd1);
        check("stall_head_pc", 32'(bus.pc), 32'h000);
        check("stall_head_insn", bus.insn, mem_word(10'h000));
        bus.insn_ready = 1'b1;
        wait_pops(6);

        // 3: memory not ready, request held stable
        do_reset();
        for (int i = 0; i < 4; i++) req_q.push_back(10'(i * 4));
        for (int i = 0; i < 5; i++) exp_q.push_back(10'(i * 4));
        reset = 1'b1; bus.imem_req_ready = 1'b1; bus.insn_ready = 1'b1;
        step(); step();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("hold_addr", 32'(bus.imem_addr), 32'h008);
        end
        bus.imem_req_ready = 1'b1;
        wait_pops(5);

        // 4: redirect with two outstanding, one queued, and a same-cycle response
        do_reset();
        lat = 3;
        req_q.push_back(10'h000); req_q.push_back(10'h004); req_q.push_back(10'h008);
        req_q.push_back(10'h040); req_q.push_back(10'h044);
        exp_q.push_back(10'h040); exp_q.push_back(10'h044); exp_q.push_back(10'h048);
        reset = 1'b1; bus.imem_req_ready = 1'b1;
        step(); step(); step();
        bus.imem_req_ready = 1'b0;
        step();
        check("pre_redir_insn_valid", 32'(bus.insn_valid), 32'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 10'h040;
        #1;
        check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        bus.redirect = 1'b0; bus.imem_req_ready = 1'b1;
        check("redir_flush", 32'(bus.insn_valid), 32'd0);
        bus.insn_ready = 1'b1;
        wait_pops(3);

        // 5: misaligned redirect near the top of the address space, then wrap
        do_reset();
        lat = 1;
        req_q.push_back(10'h3FC); req_q.push_back(10'h000);
        exp_q.push_back(10'h3FC); exp_q.push_back(10'h000); exp_q.push_back(10'h004);
        reset = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 10'h3FE;
        #1;
        check("wrap_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        check("wrap_addr", 32'(bus.imem_addr), 32'h3FC);
        bus.imem_req_ready = 1'b1; bus.insn_ready = 1'b1;
        wait_pops(3);

        // 6: asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(10'(i * 4));
        reset = 1'b1; bus.imem_req_ready = 1'b1; bus.insn_ready = 1'b1;
        wait_pops(3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_insn_valid", 32'(bus.insn_valid), 32'd0);
        check("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("arst_insn", bus.insn, 32'd0);
        check("arst_pc", 32'(bus.pc), 32'd0);
        check("arst_addr", 32'(bus.imem_addr), 32'h000);
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i * 4));
        req_q.push_back(10'h000); req_q.push_back(10'h004);
        reset = 1'b1; bus.imem_req_ready = 1'b1; bus.insn_ready = 1'b1;
        wait_pops(4);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
